tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
// PURPOSE
//   Enable sequencer for two enable-controlled tri-state drivers sharing one wire.
//   Sits directly upstream of the NOT/NAND tri-state cells and drives their EN1/EN2 pins.
//   Grants the wire to one requester at a time and inserts DEAD_CYC cycles with both
//   enables low between owners, so switch-level turn-off delays never overlap a turn-on.
//   Uses round-robin fairness and a hold limit that applies only under contention.
// PARAMETERS
//   DEAD_CYC   2   cycles with both enables low after any release; legal range 1..15
//   MAX_HOLD   8   grant cycles before forced release when the other side waits; 2..255
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   reset, synchronous, active-low
//   req1       in   1   requester 1 wants the wire (level, held while wanted)
//   req2       in   1   requester 2 wants the wire
//   en1        out  1   enable for driver 1 (EN1), registered
//   en2        out  1   enable for driver 2 (EN2), registered
//   turn       out  1   high during dead-time cycles, registered
//   hold_cnt   out  8   cycles the current owner has held the grant, registered
// BEHAVIOUR
//   - Reset: rst_n low at an edge gives IDLE, en1=en2=0, turn=0, hold_cnt=0, pref=1.
//     Applies mid-grant: the enable drops at that edge with no dead-time.
//   - States: IDLE, G1, G2, TURN. en1=(state==G1), en2=(state==G2), turn=(state==TURN).
//   - IDLE: req1 and req2 sampled at edge k; enable is high from edge k onward (1-cycle latency).
//     Both high: pref wins. None high: stay in IDLE.
//   - Gx, entry: hold_cnt=1; it then increments each cycle and saturates at 255.
//   - Gx, release when either holds:
//     * reqx=0.
//     * hold_cnt==MAX_HOLD and the other req=1.
//   - On release: go to TURN, enable low at that same edge, dead counter=DEAD_CYC-1,
//     pref = other requester.
//   - Gx with no contention: reqx=1 and the other req=0 means hold indefinitely,
//     with no forced release at MAX_HOLD.
//   - TURN: both enables low; counter decrements per cycle.
//     At the edge where the counter is 0, arbitration follows the IDLE rules
//     (grant, or IDLE if no req).
//     TURN lasts exactly DEAD_CYC cycles.
//   - Dead-time always follows a release, even when the same requester re-requests.
//   - Requests dropped during TURN are ignored; only reqs at the final TURN edge count.
//   - Invariants:
//     * en1 & en2 is never 1.
//     * An enable never rises in the cycle after the other falls, except immediately
//       after reset.
// TESTING (DEAD_CYC=2, MAX_HOLD=4)
//   1. Single req: req1=1 at edge 1 -> en1=1 after edge 1. req1=0 at edge 6 -> en1=0,
//      turn=1 for 2 cycles, then IDLE.
//   2. Tie from reset: req1=req2=1 held -> G1 for 4 cycles, TURN 2, G2 for 4, TURN 2,
//      G1 again (alternating).
//   3. No contention: req1=1 for 20 cycles, req2=0 -> en1 stays high for all 20;
//      hold_cnt reaches 20.
//   4. Same-owner re-request: req1 pulses low for 1 cycle while in G1 -> TURN lasts
//      exactly 2 cycles, then G1 again.
//   5. Reset mid-grant: rst_n=0 while en2=1 -> en2=0, hold_cnt=0 at that edge.
//      Next tie is granted to requester 1.
//   6. Random req1/req2 for 10k cycles -> assert en1&en2==0 and gap between owners >= 2,
//      every cycle.

Source files
------------

// File: rtl/tristate_bus_arbiter_if.sv
// Request/enable bundle between the requesters and the tri-state enable sequencer.
// Requesters hold req level; the arbiter answers with registered enables and status.
interface tristate_bus_arbiter_if;
  logic       req1;
  logic       req2;
  logic       en1;
  logic       en2;
  logic       turn;
  logic [7:0] hold_cnt;

  modport master (
    output req1, req2,
    input  en1, en2, turn, hold_cnt
  );

  modport slave (
    input  req1, req2,
    output en1, en2, turn, hold_cnt
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin enable sequencer for two tri-state drivers on one wire, with DEAD_CYC idle cycles per handover.
// Grant 1 cycle after a sampled request; no backpressure, requests are levels held until the enable arrives.
module tristate_bus_arbiter #(
  parameter int unsigned DEAD_CYC = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tristate_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam logic [3:0] DEAD_INIT = 4'(DEAD_CYC - 1);
  localparam logic [7:0] HOLD_LIM  = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  state_t     arb_st;
  logic [7:0] hold_q, hold_d;
  logic [3:0] dead_q, dead_d;
  logic       pref2_q, pref2_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      dead_q  <= 4'd0;
      pref2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      pref2_q <= pref2_d;
    end
  end

  // Shared by IDLE and the final TURN edge; pref2_q breaks ties.
  always_comb begin
    arb_st = IDLE;
    if (bus.req1 && bus.req2) begin
      arb_st = pref2_q ? G2 : G1;
    end else if (bus.req1) begin
      arb_st = G1;
    end else if (bus.req2) begin
      arb_st = G2;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    pref2_d = pref2_q;
    case (state_q)
      IDLE: begin
        state_d = arb_st;
        hold_d  = (arb_st == IDLE) ? 8'd0 : 8'd1;
      end
      G1: begin
        if (!bus.req1 || (hold_q == HOLD_LIM && bus.req2)) begin
          state_d = TURN;
          hold_d  = 8'd0;
          dead_d  = DEAD_INIT;
          pref2_d = 1'b1;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      G2: begin
        if (!bus.req2 || (hold_q == HOLD_LIM && bus.req1)) begin
          state_d = TURN;
          hold_d  = 8'd0;
          dead_d  = DEAD_INIT;
          pref2_d = 1'b0;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        // Requests are only looked at on the last dead cycle.
        if (dead_q == 4'd0) begin
          state_d = arb_st;
          hold_d  = (arb_st == IDLE) ? 8'd0 : 8'd1;
        end else begin
          dead_d = dead_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  assign bus.en1      = (state_q == G1);
  assign bus.en2      = (state_q == G2);
  assign bus.turn     = (state_q == TURN);
  assign bus.hold_cnt = hold_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboarded directed bench for tristate_bus_arbiter plus a random phase guarded by overlap/dead-time checks.
module tb_tristate_bus_arbiter;

  localparam int DEAD = 2;
  localparam int MAXH = 4;

  logic clk;
  logic rst_n;

  tristate_bus_arbiter_if bus ();

  tristate_bus_arbiter #(
    .DEAD_CYC (DEAD),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       e1;
    logic       e2;
    logic       t;
    logic [7:0] h;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic step(input logic rst, input logic r1, input logic r2,
                      input logic e1, input logic e2, input logic t,
                      input int h, input string tag);
    exp_t x;
    @(negedge clk);
    rst_n    = rst;
    bus.req1 = r1;
    bus.req2 = r2;
    x.e1  = e1;
    x.e2  = e2;
    x.t   = t;
    x.h   = 8'(h);
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  logic p1 = 1'b0;
  logic p2 = 1'b0;
  int   cyc = 0;
  int   last_fall = -1000;

  always begin
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp++;
      if ({bus.en1, bus.en2, bus.turn, bus.hold_cnt} !== {x.e1, x.e2, x.t, x.h}) begin
        n_bad++;
        $display("FAIL %s @%0d: got en1=%b en2=%b turn=%b hold=%0d, want en1=%b en2=%b turn=%b hold=%0d",
                 x.tag, cyc, bus.en1, bus.en2, bus.turn, bus.hold_cnt, x.e1, x.e2, x.t, x.h);
      end
    end
    n_cmp++;
    if (bus.en1 && bus.en2) begin
      n_bad++;
      $display("FAIL overlap @%0d: got en1=%b en2=%b, want never both 1", cyc, bus.en1, bus.en2);
    end
    if (!rst_n) begin
      last_fall = -1000;
    end else begin
      if ((p1 && !bus.en1) || (p2 && !bus.en2)) last_fall = cyc;
      if ((bus.en1 && !p1) || (bus.en2 && !p2)) begin
        n_cmp++;
        if (cyc - last_fall < DEAD) begin
          n_bad++;
          $display("FAIL dead_gap @%0d: got %0d idle cycles, want >= %0d", cyc, cyc - last_fall, DEAD);
        end
      end
    end
    p1 = bus.en1;
    p2 = bus.en2;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, 0, 0, "reset");

    // Single requester: grant, release, two dead cycles, idle.
    for (int h = 1; h <= 5; h++) step(1, 1, 0, 1, 0, 0, h, "t1_grant");
    step(1, 0, 0, 0, 0, 1, 0, "t1_turn");
    step(1, 0, 0, 0, 0, 1, 0, "t1_turn");
    step(1, 0, 0, 0, 0, 0, 0, "t1_idle");
    step(1, 0, 0, 0, 0, 0, 0, "t1_idle");

    // Tie from reset alternates with forced release at MAX_HOLD.
    step(0, 0, 0, 0, 0, 0, 0, "t2_rst");
    for (int h = 1; h <= MAXH; h++) step(1, 1, 1, 1, 0, 0, h, "t2_g1");
    step(1, 1, 1, 0, 0, 1, 0, "t2_turn_a");
    step(1, 1, 1, 0, 0, 1, 0, "t2_turn_a");
    for (int h = 1; h <= MAXH; h++) step(1, 1, 1, 0, 1, 0, h, "t2_g2");
    step(1, 1, 1, 0, 0, 1, 0, "t2_turn_b");
    step(1, 1, 1, 0, 0, 1, 0, "t2_turn_b");
    for (int h = 1; h <= 2; h++) step(1, 1, 1, 1, 0, 0, h, "t2_g1_again");
    step(1, 0, 0, 0, 0, 1, 0, "t2_drop");
    step(1, 0, 0, 0, 0, 1, 0, "t2_drop");
    step(1, 0, 0, 0, 0, 0, 0, "t2_idle");

    // No contention: hold indefinitely, counter saturates at 255.
    for (int h = 1; h <= 260; h++) step(1, 1, 0, 1, 0, 0, (h > 255) ? 255 : h, "t3_hold");
    step(1, 0, 0, 0, 0, 1, 0, "t3_turn");
    step(1, 0, 0, 0, 0, 1, 0, "t3_turn");
    step(1, 0, 0, 0, 0, 0, 0, "t3_idle");

    // Same owner re-requests: full dead time; early TURN requests ignored.
    step(1, 1, 0, 1, 0, 0, 1, "t4_g1");
    step(1, 1, 0, 1, 0, 0, 2, "t4_g1");
    step(1, 0, 0, 0, 0, 1, 0, "t4_pulse");
    step(1, 1, 0, 0, 0, 1, 0, "t4_turn_ignored");
    step(1, 1, 0, 1, 0, 0, 1, "t4_regrant");
    step(1, 1, 0, 1, 0, 0, 2, "t4_regrant");
    step(1, 0, 0, 0, 0, 1, 0, "t4_release");
    step(1, 0, 1, 0, 0, 1, 0, "t4_req2_ignored");
    step(1, 0, 0, 0, 0, 0, 0, "t4_idle");

    // Reset mid-grant restores preference to requester 1.
    step(1, 0, 1, 0, 1, 0, 1, "t5_g2");
    step(1, 0, 1, 0, 1, 0, 2, "t5_g2");
    step(0, 0, 1, 0, 0, 0, 0, "t5_rst");
    step(1, 1, 1, 1, 0, 0, 1, "t5_tie");
    step(1, 1, 1, 1, 0, 0, 2, "t5_tie");
    step(0, 0, 0, 0, 0, 0, 0, "t5_rst2");

    // Random requests, checked by the overlap and dead-time monitors.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 3) == 0) bus.req1 = ~bus.req1;
      if ($urandom_range(0, 3) == 0) bus.req2 = ~bus.req2;
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
